// File: rtl/uart_operand_sender_pkg.sv
// uart_operand_sender_pkg
//   Shared definitions for the UART operand sender: FSM state encoding,
//   BRAM byte-enable constants and the BRAM address width.
package uart_operand_sender_pkg;

  localparam int ADDR_W = 32;

  localparam logic [3:0] BRAM_WE_ALL  = 4'b1111;
  localparam logic [3:0] BRAM_WE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_WR_BACK   = 3'd5,
    ST_FIN       = 3'd6
  } state_t;

endpackage

// File: rtl/uart_operand_sender_if.sv
// uart_operand_sender_if
//   Bus bundle between the operand sender and its environment:
//     BRAM port A : a_addr, a_en, a_we, a_din, a_rst (to BRAM), a_dout (from BRAM)
//     UART TX     : m_axis_tdata, m_axis_tvalid (to UART), m_axis_tready (from UART)
//     UART RX     : s_axis_tdata, s_axis_tvalid (from UART), s_axis_tready (to UART)
//   master = the sender, slave = the BRAM/UART side.
interface uart_operand_sender_if;
  import uart_operand_sender_pkg::*;

  logic [ADDR_W-1:0] a_addr;
  logic              a_en;
  logic [3:0]        a_we;
  logic [31:0]       a_din;
  logic              a_rst;
  logic [31:0]       a_dout;

  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;

  modport master (
    output a_addr, a_en, a_we, a_din, a_rst,
    input  a_dout,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  modport slave (
    input  a_addr, a_en, a_we, a_din, a_rst,
    output a_dout,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );

endinterface

// File: rtl/uart_operand_sender_resp_timer.sv
// resp_timer
//   Response timeout counter, built only when RESP_TIMEOUT_EN is defined.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     load      : clear the count (issued when WAIT_RESP is entered)
//     enable    : count one cycle (high while in WAIT_RESP)
//     expired   : high once TIMEOUT_CYCLES enabled cycles have elapsed
//                 (i.e. during the last allowed cycle)
`ifdef RESP_TIMEOUT_EN
module resp_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_q;

  assign expired = (count_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/uart_operand_sender.sv
// uart_operand_sender
//   Host-side initiator for the UART byte-add service. On start it reads
//   NUM_OPS operand words from BRAM, sends their low bytes over UART TX,
//   waits for the one-byte sum on UART RX, writes it to BRAM at
//   base_addr+NUM_OPS and pulses done.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : transaction request (only honoured in IDLE)
//     base_addr  : first operand address, latched on accepted start
//     busy       : transaction in progress
//     done, err  : one-cycle completion pulse / timeout flag with done
//     result     : last received result byte
//     bus        : BRAM port A and UART TX/RX streams (master modport)
//   Optional feature macro: RESP_TIMEOUT_EN (response timeout via resp_timer);
//   without it WAIT_RESP waits forever and err is tied low.
module uart_operand_sender
  import uart_operand_sender_pkg::*;
#(
  parameter int NUM_OPS        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           result,
  uart_operand_sender_if.master bus
);

  localparam logic [7:0]        LAST_IDX = 8'(NUM_OPS - 1);
  localparam logic [ADDR_W-1:0] WB_OFS   = ADDR_W'(NUM_OPS);

  if (NUM_OPS < 1 || NUM_OPS > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_operand_sender: NUM_OPS must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        result_q, result_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic              a_en_q, a_en_d;
  logic [3:0]        a_we_q, a_we_d;
  logic [31:0]       a_din_q, a_din_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;

  // Only the operand's low byte is transmitted.
  logic unused_dout;
  assign unused_dout = ^bus.a_dout[31:8];

`ifdef RESP_TIMEOUT_EN
  logic err_q, err_d;
  logic timer_load;
  logic expired;

  resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_resp_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .enable (state_q == ST_WAIT_RESP),
    .expired(expired)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  assign bus.a_addr        = a_addr_q;
  assign bus.a_en          = a_en_q;
  assign bus.a_we          = a_we_q;
  assign bus.a_din         = a_din_q;
  assign bus.a_rst         = 1'b0;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.s_axis_tready = 1'b1;

  // BRAM and stream outputs are registered: each value is computed on the
  // transition into the state in which it must be visible.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    a_addr_d = a_addr_q;
    a_en_d   = 1'b0;
    a_we_d   = BRAM_WE_NONE;
    a_din_d  = a_din_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
`ifdef RESP_TIMEOUT_EN
    err_d      = 1'b0;
    timer_load = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          idx_d    = '0;
          busy_d   = 1'b1;
          a_addr_d = base_addr;
          a_en_d   = 1'b1;
          state_d  = ST_RD_ADDR;
        end
      end

      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        tdata_d  = bus.a_dout[7:0];
        tvalid_d = 1'b1;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        // RX bytes are ignored here, even one coinciding with the last handshake.
        if (bus.m_axis_tready) begin
          tvalid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_WAIT_RESP;
`ifdef RESP_TIMEOUT_EN
            timer_load = 1'b1;
`endif
          end else begin
            idx_d    = idx_q + 8'd1;
            a_addr_d = base_q + ADDR_W'(idx_q + 8'd1);
            a_en_d   = 1'b1;
            state_d  = ST_RD_ADDR;
          end
        end
      end

      ST_WAIT_RESP: begin
        if (bus.s_axis_tvalid) begin
          result_d = bus.s_axis_tdata;
          a_addr_d = base_q + WB_OFS;
          a_en_d   = 1'b1;
          a_we_d   = BRAM_WE_ALL;
          a_din_d  = {24'h0, bus.s_axis_tdata};
          state_d  = ST_WR_BACK;
        end
`ifdef RESP_TIMEOUT_EN
        else if (expired) begin
          // Give up: no write-back, result keeps its previous value.
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end
`endif
      end

      ST_WR_BACK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_FIN;
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      a_addr_q <= '0;
      a_en_q   <= 1'b0;
      a_we_q   <= BRAM_WE_NONE;
      a_din_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_addr_q <= a_addr_d;
      a_en_q   <= a_en_d;
      a_we_q   <= a_we_d;
      a_din_q  <= a_din_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
`ifdef RESP_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_operand_sender.sv
// tb_uart_operand_sender
//   Bench for uart_operand_sender (NUM_OPS=2). A BRAM model serves reads from
//   src[] and records write-backs; monitors log TX bytes, BRAM reads/writes
//   and done pulses. Transactions come from a vector table; reset, timeout
//   (RESP_TIMEOUT_EN) and back-pressure cases are hand-written sequences.
module tb_uart_operand_sender;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  result;

  uart_operand_sender_if bus ();

  uart_operand_sender #(
    .NUM_OPS       (2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // BRAM model: reads from src (bench-owned), writes land in wb_mem
  logic [31:0] src    [16];
  logic [31:0] wb_mem [16];
  logic [31:0] rd_log [64];
  logic [7:0]  tx_log [64];
  int          rd_cnt = 0;
  int          tx_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr_last = '0;

  always @(posedge clk) begin
    if (bus.a_en) begin
      if (bus.a_we == 4'hF) begin
        wb_mem[bus.a_addr[3:0]] <= bus.a_din;
        wr_addr_last <= bus.a_addr;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bus.a_dout <= src[bus.a_addr[3:0]];
        rd_log[rd_cnt % 64] <= bus.a_addr;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      tx_log[tx_cnt % 64] <= bus.m_axis_tdata;
      tx_cnt <= tx_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  reply;
    logic        stall;
    logic        junk;
    logic        again;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] wr;
    logic [7:0]  res;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_tx(input int target, input string nm);
    int n = 0;
    while (tx_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(tx_cnt >= target), 32'd1);
  endtask

  task automatic wait_tvalid(input string nm);
    int n = 0;
    while (!bus.m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bus.m_axis_tvalid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int tx0, rd0, wr0, dn0, n;
    logic [3:0] i0, i1;
    logic stable;
    i0 = v.base[3:0];
    i1 = v.base[3:0] + 4'd1;
    src[i0] = v.d0;
    src[i1] = v.d1;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    tx0 = tx_cnt; rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    base_addr = v.base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);

    if (v.stall) begin
      wait_tx(tx0 + 1, {tag, " first_byte"});
      bus.m_axis_tready = 1'b0;
      wait_tvalid({tag, " tvalid_2nd"});
      stable = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (!(bus.m_axis_tvalid === 1'b1 && bus.m_axis_tdata === v.tx1)) stable = 1'b0;
      end
      check({tag, " stall_stable"}, 32'(stable), 32'd1);
      check({tag, " stall_no_extra"}, 32'(tx_cnt - tx0), 32'd1);
      bus.m_axis_tready = 1'b1;
    end
    if (v.junk) begin
      // Junk RX byte in the same cycle as the last TX handshake
      wait_tx(tx0 + 1, {tag, " first_byte"});
      wait_tvalid({tag, " tvalid_2nd"});
      bus.s_axis_tdata  = 8'hAA;
      bus.s_axis_tvalid = 1'b1;
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
    end
    if (v.again) begin
      wait_tx(tx0 + 1, {tag, " first_byte"});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    wait_tx(tx0 + 2, {tag, " all_bytes"});
    repeat (3) @(negedge clk);
    bus.s_axis_tdata  = v.reply;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;

    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " busy_with_done"}, 32'(busy), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    @(negedge clk);
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " result"}, 32'(result), 32'(v.res));
    repeat (6) @(negedge clk);
    check({tag, " done_count"}, 32'(done_cnt - dn0), 32'd1);
    check({tag, " tx_count"}, 32'(tx_cnt - tx0), 32'd2);
    check({tag, " tx0"}, 32'(tx_log[tx0 % 64]), 32'(v.tx0));
    check({tag, " tx1"}, 32'(tx_log[(tx0 + 1) % 64]), 32'(v.tx1));
    check({tag, " rd_addr0"}, rd_log[rd0 % 64], v.rd0);
    check({tag, " rd_addr1"}, rd_log[(rd0 + 1) % 64], v.rd1);
    check({tag, " wr_count"}, 32'(wr_cnt - wr0), 32'd1);
    check({tag, " wr_addr"}, wr_addr_last, v.wr);
    check({tag, " wr_data"}, wb_mem[v.wr[3:0]], {24'h0, v.res});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, wr0, n;
    logic [7:0] res_before;

    vecs[0] = '{32'h0000_0000, 32'hDEAD_BE12, 32'h0000_0034, 8'h46, 1'b0, 1'b0, 1'b0,
                8'h12, 8'h34, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 8'h46};
    vecs[1] = '{32'h0000_0004, 32'h1111_117F, 32'hFFFF_FF34, 8'h80, 1'b1, 1'b0, 1'b0,
                8'h7F, 8'h34, 32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 8'h80};
    vecs[2] = '{32'h0000_0008, 32'h0000_0001, 32'h0000_00FF, 8'h05, 1'b0, 1'b1, 1'b0,
                8'h01, 8'hFF, 32'h0000_0008, 32'h0000_0009, 32'h0000_000A, 8'h05};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_00A5, 32'h0000_005A, 8'hFF, 1'b0, 1'b0, 1'b1,
                8'hA5, 8'h5A, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 8'hFF};

    for (int i = 0; i < 16; i++) begin
      src[i]    = 32'h0;
      wb_mem[i] = 32'h0;
    end
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst a_en", 32'(bus.a_en), 32'd0);
    check("rst a_we", 32'(bus.a_we), 32'd0);
    check("rst a_addr", bus.a_addr, 32'd0);
    check("rst a_din", bus.a_din, 32'd0);
    check("rst a_rst", 32'(bus.a_rst), 32'd0);
    check("rst s_tready", 32'(bus.s_axis_tready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a byte is pending in SEND
    src[12] = 32'h0000_0077;
    bus.m_axis_tready = 1'b0;
    base_addr = 32'h0000_000C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tvalid("rstsend tvalid");
    check("rstsend tdata", 32'(bus.m_axis_tdata), 32'h77);
    rst = 1'b1;
    @(negedge clk);
    check("rstsend tvalid_drop", 32'(bus.m_axis_tvalid), 32'd0);
    check("rstsend busy", 32'(busy), 32'd0);
    check("rstsend result", 32'(result), 32'd0);
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rstsend no_tx", 32'(bus.m_axis_tvalid), 32'd0);
    run_vec(vecs[0], "after_rst");

`ifdef RESP_TIMEOUT_EN
    // No reply: give up after 50 WAIT_RESP cycles, no write-back
    res_before = result;
    src[0] = 32'h0000_0012;
    src[1] = 32'h0000_0034;
    @(negedge clk);
    tx0 = tx_cnt;
    wr0 = wr_cnt;
    base_addr = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tx(tx0 + 2, "tmo all_bytes");
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo done", 32'(done), 32'd1);
    check("tmo err", 32'(err), 32'd1);
    check("tmo cycle", 32'(n), 32'd51);
    check("tmo busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("tmo err_width", 32'(err), 32'd0);
    check("tmo no_write", 32'(wr_cnt - wr0), 32'd0);
    check("tmo result_kept", 32'(result), 32'(res_before));
`else
    tx0 = 0; wr0 = 0; n = 0; res_before = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
